// File: rtl/pixel_packer.sv
// pixel_packer
//
// Gathers a stream of unpacked_width_p-bit elements into packed_width_p-bit
// words, first element in the LSBs. The element ordering matches the
// downstream unpacker, so a packer->unpacker loop reproduces the input stream.
// A one-deep output register lets the block take one element per cycle while
// a completed word waits for downstream.
//
// Optional feature macro: PIXEL_PACKER_FLUSH_EN
//   defined   : last_i completes a word early (zero padded) and last_o marks it;
//               ready_o = !valid_o | ready_i
//   undefined : last_i ignored, last_o tied 0, words complete at packed_num_p
//               elements; ready_o also stays high while the element cannot
//               complete a word
//
// Ports
//   clk_i       in   clock, rising edge
//   reset_ni    in   asynchronous active-low reset
//   unpacked_i  in   input element
//   valid_i     in   input element valid
//   ready_o     out  element accepted this cycle (0 while in reset)
//   last_i      in   final element of a frame (flush build only)
//   packed_o    out  packed word
//   valid_o     out  packed_o valid
//   ready_i     in   downstream accepts packed_o
//   last_o      out  packed_o is the final word of a frame (flush build only)

module pixel_packer #(
    parameter int unpacked_width_p = 2,
    parameter int packed_num_p     = 4,
    parameter int packed_width_p   = unpacked_width_p * packed_num_p
) (
    input  logic                        clk_i,
    input  logic                        reset_ni,
    input  logic [unpacked_width_p-1:0] unpacked_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic                        last_i,
    output logic [packed_width_p-1:0]   packed_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic                        last_o
);

    localparam int COUNT_W = (packed_num_p > 1) ? $clog2(packed_num_p) : 1;
    localparam logic [COUNT_W-1:0] MAX_C = COUNT_W'(packed_num_p - 1);

    logic [packed_width_p-1:0] acc_q, acc_d;
    logic [COUNT_W-1:0]        count_q, count_d;
    logic [packed_width_p-1:0] packed_q, packed_d;
    logic                      valid_q, valid_d;
    logic                      last_q, last_d;

    logic                      ready_c;
    logic                      early_c;
    logic                      in_fire_c;
    logic                      out_fire_c;
    logic                      complete_c;
    logic [packed_width_p-1:0] merged_c;

`ifdef PIXEL_PACKER_FLUSH_EN
    assign early_c = last_i;
    // Any element may complete a word, so only the output register state gates input.
    assign ready_c = reset_ni & (~valid_q | ready_i);
`else
    logic unused_last;
    assign unused_last = last_i;
    assign early_c     = 1'b0;
    // Only the element landing in the top slot needs room in the output register.
    assign ready_c     = reset_ni & (~valid_q | ready_i | (count_q != MAX_C));
`endif

    assign in_fire_c  = valid_i & ready_c;
    assign out_fire_c = valid_q & ready_i;
    assign complete_c = in_fire_c & ((count_q == MAX_C) | early_c);

    // Accumulator with the incoming element placed in slot count_q; slots
    // above it are forced to zero so an early-completed word is zero padded.
    always_comb begin
        merged_c = '0;
        for (int k = 0; k < packed_num_p; k++) begin
            if (k < int'(count_q)) begin
                merged_c[k*unpacked_width_p +: unpacked_width_p] =
                    acc_q[k*unpacked_width_p +: unpacked_width_p];
            end else if (k == int'(count_q)) begin
                merged_c[k*unpacked_width_p +: unpacked_width_p] = unpacked_i;
            end
        end
    end

    always_comb begin
        acc_d    = acc_q;
        count_d  = count_q;
        packed_d = packed_q;
        valid_d  = valid_q;
        last_d   = last_q;

        if (complete_c) begin
            acc_d    = '0;
            count_d  = '0;
            packed_d = merged_c;
            valid_d  = 1'b1;
            last_d   = early_c;
        end else begin
            if (in_fire_c) begin
                acc_d   = merged_c;
                count_d = count_q + COUNT_W'(1);
            end
            if (out_fire_c) begin
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            acc_q    <= '0;
            count_q  <= '0;
            packed_q <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            count_q  <= count_d;
            packed_q <= packed_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
        end
    end

    assign ready_o  = ready_c;
    assign packed_o = packed_q;
    assign valid_o  = valid_q;
    assign last_o   = last_q;

endmodule

// File: tb/tb_pixel_packer.sv
module tb_pixel_packer;

    logic       clk_i = 1'b0;
    logic       reset_ni;
    logic [1:0] unpacked_i;
    logic       valid_i;
    logic       ready_o;
    logic       last_i;
    logic [7:0] packed_o;
    logic       valid_o;
    logic       ready_i;
    logic       last_o;

    int checks = 0;
    int errors = 0;

    pixel_packer dut (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .unpacked_i (unpacked_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .last_i     (last_i),
        .packed_o   (packed_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .last_o     (last_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [1:0] word_b [4];
        logic [1:0] seq_e  [4];

        reset_ni   = 1'b0;
        valid_i    = 1'b0;
        unpacked_i = 2'd0;
        last_i     = 1'b0;
        ready_i    = 1'b1;
        #2;
        chk("rst_ready", ready_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_packed", packed_o, 0);
        chk("rst_last", last_o, 0);
        tick();
        tick();
        reset_ni = 1'b1;
        #1;
        chk("post_rst_ready", ready_o, 1);

        // Single word 1,2,3,0 -> 0x39
        valid_i = 1'b1;
        unpacked_i = 2'd1; tick();
        unpacked_i = 2'd2; tick();
        unpacked_i = 2'd3; tick();
        chk("w1_not_yet", valid_o, 0);
        unpacked_i = 2'd0; tick();
        valid_i = 1'b0;
        unpacked_i = 2'd3;
        chk("w1_valid", valid_o, 1);
        chk("w1_packed", packed_o, 32'h39);
        tick();
        chk("w1_drained", valid_o, 0);
        chk("idle_packed_hold", packed_o, 32'h39);

        // Continuous stream 0..3 x4 -> four 0xE4 words, every 4th cycle
        valid_i = 1'b1;
        for (int k = 0; k < 16; k++) begin
            unpacked_i = 2'(k % 4);
            #0;
            chk("stream_ready", ready_o, 1);
            tick();
            if (k % 4 == 3) begin
                chk("stream_valid_hi", valid_o, 1);
                chk("stream_packed", packed_o, 32'hE4);
            end else begin
                chk("stream_valid_lo", valid_o, 0);
            end
        end
        valid_i = 1'b0;
        tick();
        chk("stream_drained", valid_o, 0);

        // Stall: first word 0x39 held while second word 2,0,1,3 (0xD2) gathers
        valid_i = 1'b1;
        unpacked_i = 2'd1; tick();
        unpacked_i = 2'd2; tick();
        unpacked_i = 2'd3; tick();
        unpacked_i = 2'd0; tick();
        ready_i = 1'b0;
        chk("stall_w1", packed_o, 32'h39);
        word_b[0] = 2'd2; word_b[1] = 2'd0; word_b[2] = 2'd1; word_b[3] = 2'd3;
        for (int k = 0; k < 3; k++) begin
            unpacked_i = word_b[k];
            #0;
            chk("stall_ready_hi", ready_o, 1);
            tick();
            chk("stall_hold_packed", packed_o, 32'h39);
            chk("stall_hold_valid", valid_o, 1);
        end
        unpacked_i = word_b[3];
        #0;
        chk("stall_ready_lo", ready_o, 0);
        tick();
        chk("stall_ready_lo2", ready_o, 0);
        chk("stall_hold2", packed_o, 32'h39);
        ready_i = 1'b1;
        #0;
        chk("release_ready", ready_o, 1);
        tick();
        // Old word drains and new word loads in the same edge: no bubble.
        chk("b2b_valid", valid_o, 1);
        chk("b2b_packed", packed_o, 32'hD2);
        valid_i = 1'b0;
        tick();
        chk("b2b_drained", valid_o, 0);

        // last_i handling: 3,1(last) then 2(last),0
        seq_e[0] = 2'd3; seq_e[1] = 2'd1; seq_e[2] = 2'd2; seq_e[3] = 2'd0;
        valid_i = 1'b1;
        unpacked_i = seq_e[0]; last_i = 1'b0; tick();
        unpacked_i = seq_e[1]; last_i = 1'b1; tick();
`ifdef PIXEL_PACKER_FLUSH_EN
        chk("flush_valid", valid_o, 1);
        chk("flush_packed", packed_o, 32'h07);
        chk("flush_last", last_o, 1);
        unpacked_i = seq_e[2]; last_i = 1'b1; tick();
        chk("flush_slot0_packed", packed_o, 32'h02);
        chk("flush_slot0_last", last_o, 1);
        valid_i = 1'b0; last_i = 1'b0;
        tick();
        chk("flush_drained", valid_o, 0);
        chk("flush_last_clr", last_o, 0);
`else
        chk("nolast_not_done", valid_o, 0);
        unpacked_i = seq_e[2]; last_i = 1'b1; tick();
        unpacked_i = seq_e[3]; last_i = 1'b0; tick();
        chk("nolast_valid", valid_o, 1);
        chk("nolast_packed", packed_o, 32'h27);
        chk("nolast_last", last_o, 0);
        valid_i = 1'b0;
        tick();
        chk("nolast_drained", valid_o, 0);
`endif

        // Reset mid-word with a full word pending
        ready_i = 1'b0;
        valid_i = 1'b1;
        last_i  = 1'b0;
        unpacked_i = 2'd3;
        tick(); tick(); tick(); tick();
        chk("pre_rst_packed", packed_o, 32'hFF);
        unpacked_i = 2'd2;
        tick(); tick();
        valid_i = 1'b0;
        #2;
        reset_ni = 1'b0;
        #1;
        chk("midrst_valid", valid_o, 0);
        chk("midrst_packed", packed_o, 0);
        chk("midrst_last", last_o, 0);
        chk("midrst_ready", ready_o, 0);
        tick();
        reset_ni = 1'b1;
        ready_i = 1'b1;
        valid_i = 1'b1;
        unpacked_i = 2'd1;
        tick(); tick(); tick();
        chk("after_rst_not_yet", valid_o, 0);
        tick();
        valid_i = 1'b0;
        chk("after_rst_valid", valid_o, 1);
        chk("after_rst_packed", packed_o, 32'h55);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
